conv_sequencer: RTL and testbench

Hardwired 3x3 convolution sequencer that sits directly upstream of the 4096x8 data RAM and drives its single read/write port. It loads the 9 kernel bytes from the bottom of RAM, then sweeps the 28x28 input image and writes one clamped 8-bit result per valid window (26x26) to an output region of the same RAM. When the sweep completes it holds `done` high, which the RAM's dump logic uses to stream results out.

---
 rtl/conv_sequencer.sv | 252 +++++++++++++++++++++++++
 tb/tb_conv_sequencer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_sequencer.sv
// conv_sequencer: hardwired 3x3 convolution engine driving a single-port 4096x8 RAM.
// Loads the signed kernel from RAM, sweeps every valid 3x3 window of the unsigned
// image, and writes one clamped 8-bit result per window back to the output region.
// All RAM-facing outputs and status flags are registered from the next-state values,
// so each output cycle reflects exactly the state the sequencer is in during that cycle.
module conv_sequencer #(
    parameter int IMG_W    = 28,
    parameter int KER_BASE = 0,
    parameter int IMG_BASE = 9,
    parameter int OUT_BASE = 793,
    parameter int SHIFT    = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  mem_rdata,
    output logic        mem_r_en,
    output logic        mem_w_en,
    output logic [11:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        busy,
    output logic        done
);

    localparam int OUT_W = IMG_W - 2;
    localparam int CW    = $clog2(IMG_W);
    localparam logic [CW-1:0] LAST_POS = CW'(OUT_W - 1);

    // The whole address map must fit in the 12-bit RAM space.
    if ((IMG_W < 3) || (KER_BASE < 0) || (IMG_BASE < 0) || (OUT_BASE < 0) ||
        (KER_BASE + 8 > 4095) ||
        (IMG_BASE + IMG_W * IMG_W - 1 > 4095) ||
        (OUT_BASE + OUT_W * OUT_W - 1 > 4095)) begin : g_addr_map_check
        $error("conv_sequencer: parameter set exceeds the 12-bit address space");
    end

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_K = 3'd1,
        ST_MAC    = 3'd2,
        ST_WR     = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    state_t                 state_r, state_s;
    logic [3:0]             step_r, step_s;
    logic [CW-1:0]          row_r, row_s;
    logic [CW-1:0]          col_r, col_s;
    logic signed [19:0]     acc_r, acc_s;
    logic signed [7:0]      ker_r [0:8];
    logic signed [7:0]      ker_s [0:8];

    logic                   mem_r_en_r, mem_r_en_s;
    logic                   mem_w_en_r, mem_w_en_s;
    logic [11:0]            mem_addr_r, mem_addr_s;
    logic [7:0]             mem_wdata_r, mem_wdata_s;
    logic                   busy_r, busy_s;
    logic                   done_r, done_s;

    // Unsigned pixel times signed kernel byte, sign-extended to accumulator width.
    function automatic logic signed [19:0] mac_term(input logic [7:0] pix,
                                                    input logic signed [7:0] k);
        logic signed [19:0] pix_e;
        logic signed [19:0] ker_e;
        pix_e = {12'd0, pix};
        ker_e = {{12{k[7]}}, k};
        return pix_e * ker_e;
    endfunction

    // Scale the accumulator and saturate into the unsigned 8-bit output range.
    function automatic logic [7:0] clamp_u8(input logic signed [19:0] a);
        logic signed [19:0] scaled;
        scaled = a >>> SHIFT;
        if (scaled < 20'sd0) begin
            return 8'd0;
        end else if (scaled > 20'sd255) begin
            return 8'd255;
        end else begin
            return scaled[7:0];
        end
    endfunction

    // Image address of window tap s (row-major 3x3) for output pixel (r,c).
    function automatic logic [11:0] img_addr(input logic [CW-1:0] r,
                                             input logic [CW-1:0] c,
                                             input logic [3:0] s);
        int i;
        int j;
        case (s)
            4'd0:    begin i = 0; j = 0; end
            4'd1:    begin i = 0; j = 1; end
            4'd2:    begin i = 0; j = 2; end
            4'd3:    begin i = 1; j = 0; end
            4'd4:    begin i = 1; j = 1; end
            4'd5:    begin i = 1; j = 2; end
            4'd6:    begin i = 2; j = 0; end
            4'd7:    begin i = 2; j = 1; end
            4'd8:    begin i = 2; j = 2; end
            default: begin i = 0; j = 0; end
        endcase
        return 12'(IMG_BASE + (int'(r) + i) * IMG_W + int'(c) + j);
    endfunction

    function automatic logic [11:0] out_addr(input logic [CW-1:0] r,
                                             input logic [CW-1:0] c);
        return 12'(OUT_BASE + int'(r) * OUT_W + int'(c));
    endfunction

    // Next-state logic: step sequencing, kernel capture, accumulation and scan position.
    always_comb begin
        state_s = state_r;
        step_s  = step_r;
        row_s   = row_r;
        col_s   = col_r;
        acc_s   = acc_r;
        ker_s   = ker_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_s = ST_LOAD_K;
                    step_s  = 4'd0;
                    row_s   = '0;
                    col_s   = '0;
                end else begin
                    state_s = state_r;
                end
            end
            ST_LOAD_K: begin
                // Read data lags the read by one cycle, so step s captures byte s-1.
                if (step_r != 4'd0) begin
                    ker_s[step_r - 4'd1] = mem_rdata;
                end else begin
                    ker_s = ker_r;
                end
                if (step_r == 4'd9) begin
                    state_s = ST_MAC;
                    step_s  = 4'd0;
                end else begin
                    step_s = step_r + 4'd1;
                end
            end
            ST_MAC: begin
                if (step_r == 4'd0) begin
                    acc_s = 20'sd0;
                end else begin
                    acc_s = acc_r + mac_term(mem_rdata, ker_r[step_r - 4'd1]);
                end
                if (step_r == 4'd9) begin
                    state_s = ST_WR;
                    step_s  = 4'd0;
                end else begin
                    step_s = step_r + 4'd1;
                end
            end
            ST_WR: begin
                if ((row_r == LAST_POS) && (col_r == LAST_POS)) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_MAC;
                    step_s  = 4'd0;
                    if (col_r == LAST_POS) begin
                        col_s = '0;
                        row_s = row_r + CW'(1);
                    end else begin
                        col_s = col_r + CW'(1);
                    end
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Output values for the upcoming cycle, derived from the next state; address and
    // write data hold whenever neither enable is asserted.
    always_comb begin
        mem_r_en_s  = 1'b0;
        mem_w_en_s  = 1'b0;
        mem_addr_s  = mem_addr_r;
        mem_wdata_s = mem_wdata_r;
        case (state_s)
            ST_LOAD_K: begin
                if (step_s <= 4'd8) begin
                    mem_r_en_s = 1'b1;
                    mem_addr_s = 12'(KER_BASE + int'(step_s));
                end else begin
                    mem_r_en_s = 1'b0;
                end
            end
            ST_MAC: begin
                if (step_s <= 4'd8) begin
                    mem_r_en_s = 1'b1;
                    mem_addr_s = img_addr(row_s, col_s, step_s);
                end else begin
                    mem_r_en_s = 1'b0;
                end
            end
            ST_WR: begin
                mem_w_en_s  = 1'b1;
                mem_addr_s  = out_addr(row_s, col_s);
                mem_wdata_s = clamp_u8(acc_s);
            end
            default: begin
                mem_r_en_s = 1'b0;
            end
        endcase
        busy_s = (state_s == ST_LOAD_K) || (state_s == ST_MAC) || (state_s == ST_WR);
        done_s = (state_s == ST_DONE);
    end

    // State, datapath and registered outputs; reset clears everything immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            step_r      <= 4'd0;
            row_r       <= '0;
            col_r       <= '0;
            acc_r       <= 20'sd0;
            for (int k = 0; k < 9; k++) begin
                ker_r[k] <= 8'sd0;
            end
            mem_r_en_r  <= 1'b0;
            mem_w_en_r  <= 1'b0;
            mem_addr_r  <= 12'd0;
            mem_wdata_r <= 8'd0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            step_r      <= step_s;
            row_r       <= row_s;
            col_r       <= col_s;
            acc_r       <= acc_s;
            ker_r       <= ker_s;
            mem_r_en_r  <= mem_r_en_s;
            mem_w_en_r  <= mem_w_en_s;
            mem_addr_r  <= mem_addr_s;
            mem_wdata_r <= mem_wdata_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
        end
    end

    assign mem_r_en  = mem_r_en_r;
    assign mem_w_en  = mem_w_en_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign busy      = busy_r;
    assign done      = done_r;

endmodule

// File: tb/tb_conv_sequencer.sv
// Bench for conv_sequencer: two instances (default SHIFT and SHIFT=2), each with a
// behavioural 1-cycle-latency RAM. Expected writes are queued when a pass is set up
// and popped by a monitor on every write the DUT issues.
module tb_conv_sequencer;

    localparam int W   = 28;
    localparam int OW  = 26;
    localparam int OB  = 793;
    localparam int NPX = 676;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start0, start1;
    logic [7:0]  rdata0, rdata1;
    logic        r_en0, w_en0, busy0, done0;
    logic        r_en1, w_en1, busy1, done1;
    logic [11:0] addr0, addr1;
    logic [7:0]  wdata0, wdata1;

    logic [7:0]  ram0 [0:4095];
    logic [7:0]  ram1 [0:4095];
    logic [19:0] q0 [$];
    logic [19:0] q1 [$];

    int tests = 0;
    int fails = 0;
    int wr_cnt0 = 0;
    int wr_cnt1 = 0;
    int mk [9];
    int mim [784];
    logic [7:0] snap [0:NPX-1];

    wire [23:0] outs0 = {r_en0, w_en0, busy0, done0, addr0, wdata0};
    wire [23:0] outs1 = {r_en1, w_en1, busy1, done1, addr1, wdata1};

    always #5 clk = ~clk;

    conv_sequencer dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .mem_rdata(rdata0),
        .mem_r_en(r_en0), .mem_w_en(w_en0), .mem_addr(addr0), .mem_wdata(wdata0),
        .busy(busy0), .done(done0)
    );

    conv_sequencer #(.SHIFT(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .mem_rdata(rdata1),
        .mem_r_en(r_en1), .mem_w_en(w_en1), .mem_addr(addr1), .mem_wdata(wdata1),
        .busy(busy1), .done(done1)
    );

    // RAM models: registered read data, write on the rising edge.
    always @(posedge clk) begin
        if (r_en0) rdata0 <= ram0[addr0];
        if (w_en0) ram0[addr0] = wdata0;
        if (r_en1) rdata1 <= ram1[addr1];
        if (w_en1) ram1[addr1] = wdata1;
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: direct 3x3 window sum over the model arrays, shifted and saturated.
    function automatic int ref_pix(input int r, input int c, input int sh);
        int s = 0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                s += mim[(r + i) * W + c + j] * mk[i * 3 + j];
        s = s >>> sh;
        if (s < 0) s = 0;
        if (s > 255) s = 255;
        return s;
    endfunction

    // Load the model into the chosen RAM and queue the expected write stream.
    task automatic setup(input int d, input int sh);
        logic [7:0] b;
        for (int k = 0; k < 9; k++) begin
            b = 8'(mk[k]);
            if (d == 0) ram0[k] = b; else ram1[k] = b;
        end
        for (int p = 0; p < W * W; p++) begin
            b = 8'(mim[p]);
            if (d == 0) ram0[9 + p] = b; else ram1[9 + p] = b;
        end
        if (d == 0) q0.delete(); else q1.delete();
        for (int r = 0; r < OW; r++)
            for (int c = 0; c < OW; c++) begin
                if (d == 0) q0.push_back({12'(OB + r * OW + c), 8'(ref_pix(r, c, sh))});
                else        q1.push_back({12'(OB + r * OW + c), 8'(ref_pix(r, c, sh))});
            end
    endtask

    task automatic fill_model(input int kmode, input int kval, input int imode, input int ival);
        for (int k = 0; k < 9; k++)
            mk[k] = (kmode == 0) ? kval : (kmode == 1) ? ((k == 4) ? 1 : 0)
                                        : int'($urandom_range(0, 255)) - 128;
        for (int p = 0; p < W * W; p++)
            mim[p] = (imode == 0) ? ival : (imode == 1) ? (p & 255)
                                         : int'($urandom_range(0, 255));
    endtask

    // One full pass on dut0 (optionally launching dut1 too), with busy-length checks.
    task automatic run_pass(input bit with1, input bit inject);
        int bc = 0;
        wr_cnt0 = 0;
        if (with1) wr_cnt1 = 0;
        @(negedge clk);
        start0 = 1'b1;
        start1 = with1;
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
        chk("start_ack_busy_ren_done", int'({busy0, r_en0, done0}), 6);
        chk("first_read_addr", int'(addr0), 0);
        while (busy0 && bc < 9000) begin
            bc++;
            start0 = inject && (bc == 500);
            @(negedge clk);
        end
        start0 = 1'b0;
        chk("busy_cycles", bc, 7446);
        chk("done_with_busy_low", int'({done0, busy0}), 2);
        chk("write_count", wr_cnt0, NPX);
        chk("queue_drained", q0.size(), 0);
    endtask

    task automatic idle_quiet(input string name, input int n);
        int bad = 0;
        repeat (n) begin
            @(negedge clk);
            if (outs0 != 24'd0 || r_en1 || w_en1) bad++;
        end
        chk(name, bad, 0);
    endtask

    // Write monitors: protocol and scoreboard comparison for each instance.
    always @(negedge clk) begin
        logic [19:0] e;
        if (rst_n && (r_en0 || w_en0)) begin
            chk("rw_exclusive0", int'(r_en0 & w_en0), 0);
            if (w_en0) begin
                wr_cnt0++;
                chk("wr_not_below_out0", int'(addr0 >= 12'd793), 1);
                if (q0.size() == 0) begin
                    chk("unexpected_write0", int'(addr0), -1);
                end else begin
                    e = q0.pop_front();
                    chk("wr_addr0", int'(addr0), int'(e[19:8]));
                    chk("wr_data0", int'(wdata0), int'(e[7:0]));
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [19:0] e;
        if (rst_n && (r_en1 || w_en1)) begin
            chk("rw_exclusive1", int'(r_en1 & w_en1), 0);
            if (w_en1) begin
                wr_cnt1++;
                if (q1.size() == 0) begin
                    chk("unexpected_write1", int'(addr1), -1);
                end else begin
                    e = q1.pop_front();
                    chk("wr_addr1", int'(addr1), int'(e[19:8]));
                    chk("wr_data1", int'(wdata1), int'(e[7:0]));
                end
            end
        end
    end

    initial begin
        int bad;
        rst_n  = 1'b0;
        start0 = 1'b0;
        start1 = 1'b0;
        for (int a = 0; a < 4096; a++) begin
            ram0[a] = 8'd0;
            ram1[a] = 8'd0;
        end
        repeat (3) @(negedge clk);
        chk("reset_state0", int'(outs0), 0);
        chk("reset_state1", int'(outs1), 0);
        rst_n = 1'b1;
        idle_quiet("idle_after_reset", 100);

        // dut1: SHIFT=2, kernel all 1, image all 20 -> 180>>>2 = 45.
        fill_model(0, 1, 0, 20);
        setup(1, 2);
        // dut0: identity kernel on the ramp image.
        fill_model(1, 0, 1, 0);
        setup(0, 0);
        run_pass(1'b1, 1'b0);
        chk("id_ram793", int'(ram0[793]), 29);
        // out(25,25) = pixel(26,26) = (26*28+26) & 0xFF
        chk("id_ram1468", int'(ram0[1468]), 242);
        chk("shift_done1", int'({done1, busy1}), 2);
        chk("shift_writes1", wr_cnt1, NPX);
        chk("shift_queue1", q1.size(), 0);
        chk("shift_ram793", int'(ram1[793]), 45);
        bad = 0;
        repeat (200) begin
            @(negedge clk);
            if (!done0 || busy0 || r_en0 || w_en0) bad++;
        end
        chk("done_holds", bad, 0);

        // Box sum, image 10 -> 90; ignored start at busy cycle 500.
        fill_model(0, 1, 0, 10);
        setup(0, 0);
        run_pass(1'b0, 1'b1);
        chk("box10_ram1000", int'(ram0[1000]), 90);

        // Box sum on saturated image -> positive clamp.
        fill_model(0, 1, 0, 255);
        setup(0, 0);
        run_pass(1'b0, 1'b0);
        chk("box255_ram1468", int'(ram0[1468]), 255);

        // Kernel all -1 -> negative clamp.
        fill_model(0, -1, 0, 50);
        setup(0, 0);
        run_pass(1'b0, 1'b0);
        chk("neg_ram793", int'(ram0[793]), 0);

        // Random kernel and image.
        fill_model(2, 0, 2, 0);
        setup(0, 0);
        run_pass(1'b0, 1'b0);

        // Mid-pass asynchronous reset.
        fill_model(2, 0, 2, 0);
        setup(0, 0);
        @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (1500) @(negedge clk);
        chk("busy_before_reset", int'(busy0), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_outs0", int'(outs0), 0);
        chk("async_reset_outs1", int'(outs1), 0);
        q0.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle_quiet("idle_after_midreset", 50);

        // Fresh random pass after reset, then repeat from DONE with cleared output.
        fill_model(2, 0, 2, 0);
        setup(0, 0);
        run_pass(1'b0, 1'b0);
        for (int p = 0; p < NPX; p++) begin
            snap[p] = ram0[OB + p];
            ram0[OB + p] = 8'd0;
        end
        setup(0, 0);
        run_pass(1'b0, 1'b0);
        bad = 0;
        for (int p = 0; p < NPX; p++)
            if (ram0[OB + p] != snap[p]) bad++;
        chk("repeat_identical", bad, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
